// File: rtl/mm_pkg.sv
// Shared matrix-multiply datapath definitions: default widths and the
// dot-product stage FSM encoding.
package mm_pkg;

    localparam int DATA_W_DFLT = 16;
    localparam int LEN_W_DFLT  = 8;
    localparam int ACC_W_DFLT  = 40;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mul_stage.sv
// Registered unsigned DATA_W x DATA_W multiplier with valid pipelining,
// kept separate so it maps cleanly onto a DSP slice.
module mul_stage
    import mm_pkg::*;
#(
    parameter int DATA_W = DATA_W_DFLT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic                  valid_out,
    output logic [2*DATA_W-1:0]   prod
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out <= 1'b0;
            prod      <= '0;
        end else begin
            valid_out <= valid_in;
            if (valid_in) begin
                prod <= (2*DATA_W)'(a) * (2*DATA_W)'(b);
            end
        end
    end

endmodule

// File: rtl/mac_accumulator.sv
// Dot-product stage: multiplies LEN operand pairs and sums the products into one
// DATA_W result. Optional clamping of the result is enabled by SATURATE_EN.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high; valid without ready has no effect, and out_data/overflow stay stable
// while out_valid is high until the transfer.
module mac_accumulator
    import mm_pkg::*;
#(
    parameter int DATA_W = DATA_W_DFLT,
    parameter int LEN_W  = LEN_W_DFLT,
    parameter int ACC_W  = ACC_W_DFLT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              overflow,
    output logic [1:0]        dbg_state
);

    state_t              state;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_sum;
    logic [LEN_W-1:0]    count;
    logic                prod_vld;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   result;
    logic                beat;
    logic                clamp;

    assign beat      = in_valid && in_ready;
    assign dbg_state = state;

    mul_stage #(.DATA_W(DATA_W)) u_mul (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (beat),
        .a         (in_a),
        .b         (in_b),
        .valid_out (prod_vld),
        .prod      (prod)
    );

    // Product lags its beat by one cycle, so the add happens in the cycle after.
    assign acc_sum = acc + (prod_vld ? {{(ACC_W-2*DATA_W){1'b0}}, prod} : '0);
    assign clamp   = |acc_sum[ACC_W-1:DATA_W];

`ifdef SATURATE_EN
    assign result = clamp ? '1 : acc_sum[DATA_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (state == S_IDLE && start) begin
            overflow <= 1'b0;
        end else if (state == S_DRAIN && clamp) begin
            overflow <= 1'b1;
        end
    end
`else
    assign result   = acc_sum[DATA_W-1:0];
    assign overflow = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            acc       <= '0;
            count     <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc  <= '0;
                        busy <= 1'b1;
                        if (len == '0) begin
                            out_data  <= '0;
                            out_valid <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            count    <= len;
                            in_ready <= 1'b1;
                            state    <= S_ACCUM;
                        end
                    end
                end
                S_ACCUM: begin
                    acc <= acc_sum;
                    if (beat) begin
                        count <= count - LEN_W'(1);
                        if (count == LEN_W'(1)) begin
                            in_ready <= 1'b0;
                            state    <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    acc       <= acc_sum;
                    out_data  <= result;
                    out_valid <= 1'b1;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed testbench for mac_accumulator; expectations adapt to SATURATE_EN.
module tb_mac_accumulator;
  import mm_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        busy;
  logic        overflow;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad = 0;
  logic [15:0] exp_q[$];

  mac_accumulator dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .overflow  (overflow),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic start_run(input logic [7:0] l);
    start = 1'b1;
    len = l;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    in_a = $urandom_range(0, 65535);
    in_b = $urandom_range(0, 65535);
  endtask

  // scoreboard: waits for a result, optionally stalls out_ready, then completes the handshake
  task automatic wait_result(input int hold, input logic exp_ovf);
    int n = 0;
    logic [15:0] exp;
    exp = exp_q.pop_front();
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    check("out_valid_timeout", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < hold; i++) begin
      check("hold_data", {16'd0, out_data}, {16'd0, exp});
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      tick();
    end
    out_ready = 1'b1;
    check("out_data", {16'd0, out_data}, {16'd0, exp});
    check("overflow", {31'd0, overflow}, {31'd0, exp_ovf});
    check("busy_done", {31'd0, busy}, 32'd1);
    tick();
    out_ready = 1'b0;
    check("post_valid", {31'd0, out_valid}, 32'd0);
    check("post_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    len = '0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {16'd0, out_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, {30'd0, S_IDLE});

    // 1: three back-to-back pairs, latency of two cycles
    exp_q.push_back(16'd16);
    start_run(8'd3);
    check("t1_busy", {31'd0, busy}, 32'd1);
    send(16'd10, 16'd1);
    send(16'd0, 16'd231);
    send(16'd2, 16'd3);
    check("t1_lat_early", {31'd0, out_valid}, 32'd0);
    check("t1_in_ready_off", {31'd0, in_ready}, 32'd0);
    tick();
    check("t1_lat_valid", {31'd0, out_valid}, 32'd1);
    wait_result(0, 1'b0);

    // 2: zero-length run
    exp_q.push_back(16'd0);
    start_run(8'd0);
    check("t2_valid_next", {31'd0, out_valid}, 32'd1);
    check("t2_in_ready", {31'd0, in_ready}, 32'd0);
    wait_result(0, 1'b0);

    // 3: input gaps, output stall, start ignored in DONE
    exp_q.push_back(16'd57);
    start_run(8'd2);
    send(16'd7, 16'd8);
    repeat (4) tick();
    check("t3_gap_ready", {31'd0, in_ready}, 32'd1);
    check("t3_gap_state", {30'd0, dbg_state}, {30'd0, S_ACCUM});
    send(16'd1, 16'd1);
    tick();
    start = 1'b1;
    len = 8'd5;
    tick();
    start = 1'b0;
    check("t3_start_ignored", {30'd0, dbg_state}, {30'd0, S_DONE});
    wait_result(4, 1'b0);
    tick();
    check("t3_stay_idle", {30'd0, dbg_state}, {30'd0, S_IDLE});

    // 4: result beyond DATA_W
`ifdef SATURATE_EN
    exp_q.push_back(16'd65535);
`else
    exp_q.push_back(16'd64464);
`endif
    start_run(8'd2);
    send(16'd300, 16'd300);
    send(16'd200, 16'd200);
`ifdef SATURATE_EN
    wait_result(1, 1'b1);
`else
    wait_result(1, 1'b0);
`endif

    // 5: reset mid-run, then a fresh run
    start_run(8'd3);
    send(16'd9, 16'd9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_in_ready", {31'd0, in_ready}, 32'd0);
    check("t5_out_valid", {31'd0, out_valid}, 32'd0);
    check("t5_out_data", {16'd0, out_data}, 32'd0);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_overflow", {31'd0, overflow}, 32'd0);
    check("t5_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    exp_q.push_back(16'd20);
    start_run(8'd1);
    send(16'd4, 16'd5);
    wait_result(0, 1'b0);

    // 6: start held through the DONE handshake
    exp_q.push_back(16'd6);
    exp_q.push_back(16'd27);
    start = 1'b1;
    len = 8'd1;
    tick();
    len = 8'd2;
    send(16'd2, 16'd3);
    wait_result(0, 1'b0);
    tick();
    start = 1'b0;
    check("t6_restart_busy", {31'd0, busy}, 32'd1);
    check("t6_restart_state", {30'd0, dbg_state}, {30'd0, S_ACCUM});
    send(16'd5, 16'd5);
    send(16'd1, 16'd2);
    wait_result(0, 1'b0);

    check("exp_q_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
